// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES decrypt path.
// Holds the FSM state enum, legal round counts and the inverse S-box.
package aes_dec_pkg;

  localparam int BLK_W     = 128;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } dec_state_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); zero maps to zero.
  function automatic logic [7:0] ginv(
    input logic [7:0] a
  );
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  // Undo the S-box affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(
    input logic [7:0] s
  );
    logic [7:0] b;
    b = {s[6:0], s[7]}
      ^ {s[4:0], s[7:5]}
      ^ {s[1:0], s[7:2]}
      ^ 8'h05;
    return ginv(b);
  endfunction

endpackage

// File: rtl/aes_inv_mix_columns.sv
// AES InvMixColumns on a full 128-bit state, column-major bytes.
// Ports: din (state in), dout (state out); purely combinational.
module aes_inv_mix_columns
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);

  function automatic logic [31:0] mix_col(
    input logic [31:0] a
  );
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
        ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
        ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
        ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
        ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
    };
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign dout[BLK_W-1-32*c -: 32] =
      mix_col(din[BLK_W-1-32*c -: 32]);
  end

endmodule

// File: rtl/aes_inv_round_comb.sv
// One AES inverse round: InvShiftRows, InvSubBytes, key add, InvMixColumns.
// Ports: state, key, last (skip InvMixColumns), result; combinational.
module aes_inv_round_comb
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] key,
  input  logic             last,
  output logic [BLK_W-1:0] result
);

  logic [BLK_W-1:0] sub_b;
  logic [BLK_W-1:0] ark;
  logic [BLK_W-1:0] mixed;

  // Byte k = 4*col + row, MSB first; row r rotates right by r.
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      localparam int DST = 4 * c + r;
      assign sub_b[BLK_W-1-8*DST -: 8] =
        inv_sbox(state[BLK_W-1-8*SRC -: 8]);
    end
  end

  assign ark = sub_b ^ key;

  aes_inv_mix_columns u_mix (
    .din  (ark),
    .dout (mixed)
  );

  assign result = last ? ark : mixed;

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse cipher, one round per clock, keys fetched by index.
// Ports: in_* / out_* valid-ready, rk_idx/rk_data, busy; flush if AES_DEC_FLUSH_EN.
module aes_inv_round_ctrl
  import aes_dec_pkg::*;
#(
  parameter int NR    = 10,
  parameter int RK_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic [RK_AW-1:0] rk_idx,
  input  logic [BLK_W-1:0] rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
`ifdef AES_DEC_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  if (NR != NR_AES128 && NR != NR_AES192
      && NR != NR_AES256) begin : g_bad_nr
    $error("aes_inv_round_ctrl: NR=%0d illegal", NR);
  end

  if ((2 ** RK_AW) <= NR) begin : g_bad_aw
    $error("aes_inv_round_ctrl: RK_AW too small");
  end

  dec_state_e       fsm_q;
  logic [BLK_W-1:0] state_q;
  logic [RK_AW-1:0] rnd_q;
  logic [BLK_W-1:0] round_out;
  logic             flush_i;

`ifdef AES_DEC_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  aes_inv_round_comb u_round (
    .state  (state_q),
    .key    (rk_data),
    .last   (fsm_q == FINAL),
    .result (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else if (flush_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_data ^ rk_data;
            rnd_q   <= RK_AW'(NR - 1);
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_out;
          if (rnd_q == RK_AW'(1)) begin
            fsm_q <= FINAL;
          end else begin
            rnd_q <= rnd_q - RK_AW'(1);
          end
        end
        FINAL: begin
          state_q <= round_out;
          fsm_q   <= DONE;
        end
        DONE: begin
          if (out_ready) fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = out_valid ? state_q : '0;

  always_comb begin
    rk_idx = RK_AW'(NR);
    unique case (1'b1)
      (fsm_q == ROUND): rk_idx = rnd_q;
      (fsm_q == FINAL): rk_idx = '0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl (NR=10 and NR=14 instances).
// Reference: FIPS-197 vectors plus a table-driven AES inverse-cipher model.
module tb_aes_inv_round_ctrl;

  localparam int NR10 = 10;
  localparam int NR14 = 14;

  localparam logic [127:0] C1_CT =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT =
    128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk;
  logic rst_n;

  logic         d10_in_valid, d10_in_ready;
  logic [127:0] d10_in_data, d10_rk_data, d10_out_data;
  logic [3:0]   d10_rk_idx;
  logic         d10_out_valid, d10_out_ready, d10_busy;

  logic         d14_in_valid, d14_in_ready;
  logic [127:0] d14_in_data, d14_rk_data, d14_out_data;
  logic [3:0]   d14_rk_idx;
  logic         d14_out_valid, d14_out_ready, d14_busy;

`ifdef AES_DEC_FLUSH_EN
  logic d10_flush;
  logic d14_flush;
`endif

  logic [7:0]   sb  [0:255];
  logic [7:0]   isb [0:255];
  logic [127:0] ks10 [0:10];
  logic [127:0] ks14 [0:14];

  int checks;
  int failures;

  assign d10_rk_data = ks10[d10_rk_idx];
  assign d14_rk_data = ks14[d14_rk_idx];

  aes_inv_round_ctrl #(.NR(NR10), .RK_AW(4)) u10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d10_in_valid),
    .in_ready  (d10_in_ready),
    .in_data   (d10_in_data),
    .rk_idx    (d10_rk_idx),
    .rk_data   (d10_rk_data),
    .out_valid (d10_out_valid),
    .out_ready (d10_out_ready),
    .out_data  (d10_out_data),
    .busy      (d10_busy)
`ifdef AES_DEC_FLUSH_EN
    ,
    .flush     (d10_flush)
`endif
  );

  aes_inv_round_ctrl #(.NR(NR14), .RK_AW(4)) u14 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d14_in_valid),
    .in_ready  (d14_in_ready),
    .in_data   (d14_in_data),
    .rk_idx    (d14_rk_idx),
    .rk_data   (d14_rk_data),
    .out_valid (d14_out_valid),
    .out_ready (d14_out_ready),
    .out_data  (d14_out_data),
    .busy      (d14_busy)
`ifdef AES_DEC_FLUSH_EN
    ,
    .flush     (d14_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chkw(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag,
                      input int obs,
                      input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // GF(2^8) product: carry-less multiply, then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul_m(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Forward S-box from brute-force field inverse plus affine map;
  // the inverse S-box is its table inverse.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul_m(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = s[i] ^ inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
             ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key,
                                             input int nk,
                                             input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (r + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul_m(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [7:0] bget(input logic [127:0] st,
                                      input int r, input int c);
    return st[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [127:0] inv_rows_sub(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = isb[bget(st, r, (c + 4 - r) % 4)];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] st);
    logic [127:0] o;
    logic [7:0]   mc [4];
    logic [7:0]   acc;
    mc[0] = 8'h0e; mc[1] = 8'h0b; mc[2] = 8'h0d; mc[3] = 8'h09;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul_m(mc[(j - r + 4) % 4], bget(st, j, c));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct,
                                             input logic [255:0] key,
                                             input int nk,
                                             input int nr);
    logic [127:0] st;
    st = ct ^ round_key(key, nk, nr);
    for (int rd = nr - 1; rd >= 0; rd--) begin
      st = inv_rows_sub(st) ^ round_key(key, nk, rd);
      if (rd > 0) st = inv_mix(st);
    end
    return st;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic run10(input logic [127:0] ct,
                       input logic [127:0] exp,
                       input int hold,
                       input bit seq);
    int n;
    @(negedge clk);
    d10_out_ready = 1'b0;
    d10_in_valid  = 1'b1;
    d10_in_data   = ct;
    chk1("idle_in_ready", d10_in_ready, 1'b1);
    chki("idle_rk_idx", int'(d10_rk_idx), NR10);
    @(negedge clk);
    d10_in_valid = 1'b0;
    d10_in_data  = rnd128();
    n = 0;
    while (!d10_out_valid && n < 40) begin
      if (seq) begin
        chki("rk_seq", int'(d10_rk_idx), NR10 - 1 - n);
        chk1("busy_run", d10_busy, 1'b1);
        chk1("in_ready_run", d10_in_ready, 1'b0);
      end
      @(negedge clk);
      n++;
    end
    chki("latency10", n, NR10);
    chkw("out_data10", d10_out_data, exp);
    d10_in_valid = 1'b1;
    d10_in_data  = rnd128();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("stall_valid", d10_out_valid, 1'b1);
      chkw("stall_data", d10_out_data, exp);
      chk1("stall_in_ready", d10_in_ready, 1'b0);
    end
    d10_in_valid  = 1'b0;
    d10_out_ready = 1'b1;
    @(negedge clk);
    d10_out_ready = 1'b0;
    chk1("post_valid10", d10_out_valid, 1'b0);
    chk1("post_in_ready10", d10_in_ready, 1'b1);
  endtask

  task automatic run14(input logic [127:0] ct,
                       input logic [127:0] exp);
    int n;
    @(negedge clk);
    d14_out_ready = 1'b0;
    d14_in_valid  = 1'b1;
    d14_in_data   = ct;
    @(negedge clk);
    d14_in_valid = 1'b0;
    n = 0;
    while (!d14_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chki("latency14", n, NR14);
    chkw("out_data14", d14_out_data, exp);
    d14_out_ready = 1'b1;
    @(negedge clk);
    d14_out_ready = 1'b0;
    chk1("post_valid14", d14_out_valid, 1'b0);
  endtask

  initial begin
    int acc [$];
    int outs;
    int n;
    int seen;
    logic [127:0] ct;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    d10_in_valid = 1'b0; d10_in_data = '0; d10_out_ready = 1'b0;
    d14_in_valid = 1'b0; d14_in_data = '0; d14_out_ready = 1'b0;
`ifdef AES_DEC_FLUSH_EN
    d10_flush = 1'b0;
    d14_flush = 1'b0;
`endif

    build_tables();
    for (int r = 0; r <= NR10; r++) ks10[r] = round_key(K128, 4, r);
    for (int r = 0; r <= NR14; r++) ks14[r] = round_key(K256, 8, r);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk1("rst_in_ready", d10_in_ready, 1'b1);
    chk1("rst_out_valid", d10_out_valid, 1'b0);
    chk1("rst_busy", d10_busy, 1'b0);
    chkw("rst_out_data", d10_out_data, '0);
    chki("rst_rk_idx", int'(d10_rk_idx), NR10);
    rst_n = 1'b1;

    // FIPS-197 C.1 with round-key index sequence
    run10(C1_CT, PT, 0, 1'b1);

    // Back-pressure: 20 stalled cycles in DONE
    run10(C1_CT, PT, 20, 1'b0);

    // Back-to-back with in_valid held high
    @(negedge clk);
    d10_in_valid  = 1'b1;
    d10_in_data   = C1_CT;
    d10_out_ready = 1'b1;
    outs = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (acc.size() == 2) d10_in_valid = 1'b0;
      if (d10_in_valid && d10_in_ready) acc.push_back(i);
      if (d10_out_valid) begin
        chkw("b2b_data", d10_out_data, PT);
        outs++;
      end
    end
    d10_in_valid  = 1'b0;
    d10_out_ready = 1'b0;
    chki("b2b_accepts", acc.size(), 2);
    if (acc.size() >= 2) chki("b2b_gap", acc[1] - acc[0], NR10 + 2);
    chki("b2b_outputs", outs, 2);

    // Reset in ROUND with rnd_q == 5
    @(negedge clk);
    d10_in_valid = 1'b1;
    d10_in_data  = C1_CT;
    @(negedge clk);
    d10_in_valid = 1'b0;
    n = 0;
    while (d10_rk_idx !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chki("reach_rnd5", int'(d10_rk_idx), 5);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", d10_out_valid, 1'b0);
    chk1("mid_rst_in_ready", d10_in_ready, 1'b1);
    chki("mid_rst_rk_idx", int'(d10_rk_idx), NR10);
    @(negedge clk);
    chk1("mid_rst_busy", d10_busy, 1'b0);
    chkw("mid_rst_out_data", d10_out_data, '0);
    rst_n = 1'b1;
    run10(C1_CT, PT, 0, 1'b1);

    // Random ciphertexts against the reference model
    for (int k = 0; k < 4; k++) begin
      ct = rnd128();
      run10(ct, model_dec(ct, K128, 4, NR10),
            int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef AES_DEC_FLUSH_EN
    // Flush during ROUND
    @(negedge clk);
    d10_in_valid = 1'b1;
    d10_in_data  = rnd128();
    @(negedge clk);
    d10_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    d10_flush = 1'b1;
    @(negedge clk);
    d10_flush = 1'b0;
    chk1("flush_in_ready", d10_in_ready, 1'b1);
    chk1("flush_out_valid", d10_out_valid, 1'b0);
    chk1("flush_busy", d10_busy, 1'b0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (d10_out_valid) seen++;
    end
    chki("flush_no_pulse", seen, 0);
    // flush beats in_valid in IDLE
    d10_flush    = 1'b1;
    d10_in_valid = 1'b1;
    d10_in_data  = C1_CT;
    @(negedge clk);
    chk1("flush_no_accept", d10_busy, 1'b0);
    chk1("flush_idle_ready", d10_in_ready, 1'b1);
    d10_flush    = 1'b0;
    d10_in_valid = 1'b0;
    run10(C1_CT, PT, 0, 1'b0);
`else
    seen = 0;
`endif

    // NR=14: FIPS-197 C.3 and one random block
    run14(C3_CT, PT);
    ct = rnd128();
    run14(ct, model_dec(ct, K256, 8, NR14));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
